writeback_ctrl: RTL and testbench

- Write-side initiator for the integer register file. Merges two result sources onto the file's single write port (dest_en/dest_addr/dest_data):
  - single-cycle ALU results;
  - in-order, variable-latency load responses.
- Keeps a per-register scoreboard of pending load destinations so decode can stall on RAW hazards.
- Keeps a small FIFO of outstanding load destination addresses.

---
 rtl/writeback_ctrl.sv | 117 +++++++++++
 tb/tb_writeback_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_ctrl.sv
// Register-file write-side initiator: merges ALU results and in-order load
// responses onto one write port and tracks pending load destinations.
module writeback_ctrl #(
    parameter int WIDTH      = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int LOAD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [ADDR_WIDTH-1:0] ld_issue_addr,
    input  logic                  ld_resp_valid,
    input  logic [WIDTH-1:0]      ld_resp_data,
    output logic                  dest_en,
    output logic [ADDR_WIDTH-1:0] dest_addr,
    output logic [WIDTH-1:0]      dest_data,
    output logic [REG_COUNT-1:0]  busy_mask,
    output logic                  load_pending,
    output logic                  err
);
    localparam int PTR_W = $clog2(LOAD_DEPTH);
    localparam int CNT_W = $clog2(LOAD_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LOAD_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_mem [LOAD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [REG_COUNT-1:0]  busy_reg, busy_next;
    logic                  err_reg;
    logic                  dest_en_reg;
    logic [ADDR_WIDTH-1:0] dest_addr_reg;
    logic [WIDTH-1:0]      dest_data_reg;

    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  resp_pop, issue_push, alu_fire;
    logic                  issue_busy, alu_busy;

    assign head_addr      = fifo_mem[rd_ptr_reg];
    assign load_pending   = (count_reg != '0);
    assign resp_pop       = ld_resp_valid && load_pending;
    assign issue_busy     = (ld_issue_addr != '0) && busy_reg[ld_issue_addr];
    assign alu_busy       = (alu_addr != '0) && busy_reg[alu_addr];
    assign ld_issue_ready = (count_reg < DEPTH_C) && !issue_busy;
    // A busy destination blocks the ALU so an older load cannot overwrite it.
    assign alu_ready      = !resp_pop && !alu_busy;
    assign issue_push     = ld_issue_valid && ld_issue_ready;
    assign alu_fire       = alu_valid && alu_ready;

    assign dest_en   = dest_en_reg;
    assign dest_addr = dest_addr_reg;
    assign dest_data = dest_data_reg;
    assign busy_mask = busy_reg;
    assign err       = err_reg;

    always_comb begin
        busy_next = busy_reg;
        if (resp_pop)
            busy_next[head_addr] = 1'b0;
        if (issue_push)
            busy_next[ld_issue_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = count_reg;
        case ({issue_push, resp_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (issue_push)
            fifo_mem[wr_ptr_reg] <= ld_issue_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            busy_reg      <= '0;
            err_reg       <= 1'b0;
            dest_en_reg   <= 1'b0;
            dest_addr_reg <= '0;
            dest_data_reg <= '0;
        end else begin
            if (issue_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (resp_pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            busy_reg  <= busy_next;
            if (ld_resp_valid && !load_pending)
                err_reg <= 1'b1;
            // Writes to register 0 are consumed but never enable the port.
            if (resp_pop) begin
                dest_en_reg   <= (head_addr != '0);
                dest_addr_reg <= head_addr;
                dest_data_reg <= ld_resp_data;
            end else if (alu_fire) begin
                dest_en_reg   <= (alu_addr != '0);
                dest_addr_reg <= alu_addr;
                dest_data_reg <= alu_data;
            end else begin
                dest_en_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed + randomized bench for writeback_ctrl against a queue-based model.
module tb_writeback_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        ld_issue_valid = 1'b0;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_addr = '0;
    logic        ld_resp_valid = 1'b0;
    logic [31:0] ld_resp_data = '0;
    logic        dest_en;
    logic [4:0]  dest_addr;
    logic [31:0] dest_data;
    logic [31:0] busy_mask;
    logic        load_pending;
    logic        err;

    int checks = 0;
    int failures = 0;

    // Reference model: outstanding loads as an ordered list of destinations.
    int          q[$];
    bit          m_err = 1'b0;
    bit          m_en = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_addr(ld_issue_addr),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .dest_en(dest_en), .dest_addr(dest_addr), .dest_data(dest_data),
        .busy_mask(busy_mask), .load_pending(load_pending), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        foreach (q[i]) if (q[i] != 0) v[q[i]] = 1'b1;
        return v;
    endfunction

    // One clock: check handshakes before the edge, advance model, check outputs after.
    task automatic cycle();
        logic [31:0] b;
        logic        ear, eir;
        bit          pop, push, afire;
        int          h;
        #1;
        b   = model_busy();
        ear = !(ld_resp_valid && q.size() != 0) && !(alu_addr != 0 && b[alu_addr]);
        eir = (q.size() < DEPTH) && !(ld_issue_addr != 0 && b[ld_issue_addr]);
        check("alu_ready", alu_ready, ear);
        check("ld_issue_ready", ld_issue_ready, eir);
        if (!rst_n) begin
            q.delete();
            m_err = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            pop   = ld_resp_valid && q.size() != 0;
            push  = ld_issue_valid && eir;
            afire = alu_valid && ear;
            if (ld_resp_valid && q.size() == 0) m_err = 1'b1;
            if (pop) begin
                h = q.pop_front();
                m_en = (h != 0); m_addr = 5'(h); m_data = ld_resp_data;
            end else if (afire) begin
                m_en = (alu_addr != 0); m_addr = alu_addr; m_data = alu_data;
            end else begin
                m_en = 1'b0;
            end
            if (push) q.push_back(int'(ld_issue_addr));
        end
        @(posedge clk);
        #1;
        check("dest_en", dest_en, m_en);
        check("dest_addr", dest_addr, m_addr);
        check("dest_data", dest_data, m_data);
        check("busy_mask", busy_mask, model_busy());
        check("load_pending", load_pending, q.size() != 0);
        check("err", err, m_err);
        if (dest_en) $display("write r%0d <= %08h", dest_addr, dest_data);
        @(negedge clk);
    endtask

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic iv, input logic [4:0] ia,
                        input logic rv, input logic [31:0] rd);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_issue_valid = iv; ld_issue_addr = ia;
        ld_resp_valid = rv; ld_resp_data = rd;
        cycle();
    endtask

    initial begin
        @(negedge clk);
        // Reset
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_dest_en", dest_en, 1'b0);
        check("rst_busy", busy_mask, 32'h0);
        check("rst_pending", load_pending, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // ALU write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        check("tp_alu_en", dest_en, 1'b1);
        check("tp_alu_addr", dest_addr, 5'd5);
        check("tp_alu_data", dest_data, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        check("tp_alu_en_drop", dest_en, 1'b0);
        check("tp_alu_hold", dest_data, 32'hDEADBEEF);

        // Load round trip
        step(0, 0, 0, 1, 7, 0, 0);
        check("tp_ld_busy7", busy_mask[7], 1'b1);
        check("tp_ld_pending", load_pending, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1234);
        check("tp_ld_addr", dest_addr, 5'd7);
        check("tp_ld_data", dest_data, 32'h1234);
        check("tp_ld_idle", load_pending, 1'b0);

        // Priority and WAW
        step(0, 0, 0, 1, 9, 0, 0);
        step(1, 9, 32'hAAAA, 0, 0, 0, 0);
        step(1, 9, 32'hAAAA, 0, 0, 0, 0);
        check("tp_waw_noalu", dest_en, 1'b0);
        step(1, 3, 32'h3333, 0, 0, 1, 32'h9999);
        check("tp_pri_load_first", dest_addr, 5'd9);
        step(1, 3, 32'h3333, 0, 0, 0, 0);
        check("tp_pri_alu_next", dest_addr, 5'd3);
        step(0, 0, 0, 0, 0, 0, 0);

        // Full and wrap
        for (int r = 1; r <= 4; r++) step(0, 0, 0, 1, 5'(r), 0, 0);
        step(0, 0, 0, 1, 6, 0, 0);
        check("tp_full_refuse", busy_mask[6], 1'b0);
        step(0, 0, 0, 1, 6, 1, 32'h101);
        step(0, 0, 0, 1, 6, 1, 32'h102);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 5'(10 + k), 1, 32'h200 + 32'(k));
        while (q.size() != 0) step(0, 0, 0, 0, 0, 1, $urandom());

        // Register 0 and duplicate issue
        step(1, 0, 32'h55, 0, 0, 0, 0);
        check("tp_x0_alu", dest_en, 1'b0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("tp_x0_busy", busy_mask, 32'h0);
        check("tp_x0_pending", load_pending, 1'b1);
        step(0, 0, 0, 0, 0, 1, 32'h77);
        check("tp_x0_resp", dest_en, 1'b0);
        step(0, 0, 0, 1, 4, 0, 0);
        step(0, 0, 0, 1, 4, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h44);

        // Error and mid-operation reset
        step(0, 0, 0, 0, 0, 1, 32'hBAD);
        check("tp_err_set", err, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("tp_err_hold", err, 1'b1);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 2, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        check("tp_rst_busy", busy_mask, 32'h0);
        check("tp_rst_pending", load_pending, 1'b0);
        check("tp_rst_err", err, 1'b0);
        step(0, 0, 0, 0, 0, 1, 32'h1);
        check("tp_stray_err", err, 1'b1);

        // Randomized traffic
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 (q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0),
                 $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
